multicycle_cpu: RTL and testbench
=================================

# multicycle_cpu

Parametrised multi-cycle processor core: the next generation of the team's single-cycle 8-bit CPU. Adds a PC with branching, synchronous reset, configurable data width and a single req/ready memory port that tolerates wait states, so slow or shared memories attach without stalling tricks. Sits between the system memory/arbiter and the debug/status logic; instruction format stays 16-bit (opcode, rd, rs1, rs2 as 4-bit fields).

## Interface
- DATA_W, default 8: register/ALU width, 4..16.
- ADDR_W, default 8: memory address and PC width, 4..16.
- RESET_PC, default 0: PC value loaded on reset.
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_req  out  1  memory transfer request.
- mem_we  out  1  1 = write, valid while mem_req.
- mem_addr  out  ADDR_W  word address, valid while mem_req.
- mem_wdata  out  16  write data, R[rs2] zero-extended to 16.
- mem_rdata  in  16  read data, sampled on the completing edge.
- mem_ready  in  1  completes the pending transfer; ignored when mem_req=0.
- halted  out  1  core stopped (HALT or illegal opcode).
- illegal  out  1  halt cause was opcode 0xF.
- retire  out  1  one-cycle pulse per completed instruction.

## Operation
- Registers R0..R15, DATA_W bits; R0 reads 0, writes to R0 discarded. Flags Z, C.
- Opcodes: 0 NOP; 1 ADD rd=rs1+rs2; 2 SUB rd=rs1-rs2; 3 AND; 4 OR; 5 XOR; 6 SHL rd=rs1<<1; 7 LDI rd={rs1,rs2} field bits as imm8, truncated/zero-extended to DATA_W; 8 LD rd=mem[R[rs1]][DATA_W-1:0]; 9 ST mem[R[rs1]]=R[rs2]; A JMP pc=R[rs1]; B BZ jump if Z; C BC jump if C; D CMP flags of rs1-rs2, no write; E HALT; F illegal.
- Flags written by 1-6 and D only. Z = result==0. C: ADD carry-out; SUB/CMP borrow (rs1<rs2 unsigned); SHL bit shifted out; logic ops clear C.
- Register values used as addresses/PC: zero-extended or truncated to ADDR_W. PC increments modulo 2^ADDR_W (wraps to 0).
- FSM states FETCH, EXEC, MEM, HALT.
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc. On ready: latch inst, pc<=pc+1, -> EXEC.
  - EXEC: ALU/LDI/branch/flag update, retire=1, -> FETCH; LD/ST -> MEM (no retire); E -> HALT (retire=1); F -> HALT, illegal=1 (no retire).
  - MEM: mem_req=1, addr=R[rs1], we=(ST). On ready: LD writes rd, retire=1, -> FETCH.
  - HALT: terminal until rst; mem_req=0.
- Handshake: mem_req, mem_we, mem_addr, mem_wdata held stable from assertion until the edge with mem_ready=1; mem_req may drop only after that edge.
- Branch target uses pc already incremented; taken branch replaces it.

## Timing
- Reset values: pc=RESET_PC, state FETCH, R1..R15=0, Z=C=0, mem_req=0 in the reset cycle, halted=0, illegal=0, retire=0. First mem_req on first cycle after rst falls.
- rst dominates any state, including mid-transfer: pending request abandoned, no writeback, mem_req low next cycle.
- Zero-wait memory (ready same cycle as req): non-memory ops 2 cycles, LD/ST 3 cycles. Each ready wait cycle adds 1.
- Register and flag writes visible to the next instruction (no hazards: strictly sequential).
- Outputs registered except mem_req/mem_we/mem_addr/mem_wdata, which are decoded from registered state only (no combinational path from mem_ready/mem_rdata to outputs).

## Structure
- Package cpu_pkg: opcode enum, FSM state enum, instruction field bit positions, flag indices.
- Sub-module param_alu (DATA_W): op select, a, b -> result, Z, C; combinational.
- Register file inline (R0 zero rule).

## Test plan
- Reset, zero-wait memory, program LDI R1,5; LDI R2,3; ADD R3,R1,R2; HALT -> R3=8, Z=0, C=0, retire 4 pulses, halted after 8 cycles.
- DATA_W=8: LDI R1,0xFF; LDI R2,1; ADD R3,R1,R2 -> R3=0, Z=1, C=1; then BZ to R4 -> pc=R4.
- ST mem[0x40]=0xA5 then LD R5 from 0x40 with ready delayed 3 cycles per access -> R5=0xA5, request signals stable during waits.
- ADDR_W=4, PC=15 executing NOP -> next fetch address 0; opcode 0xF -> halted=1, illegal=1, no retire.
- Assert rst during MEM wait of a LD -> rd unchanged, mem_req=0 next cycle, fetch from RESET_PC after release.
- LDI R0,7; ADD R1,R0,R0 -> R1=0 (R0 hardwired zero).

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the multicycle CPU: opcodes, FSM states, instruction fields, flags.
package cpu_pkg;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0,
      OP_ADD  = 4'h1,
      OP_SUB  = 4'h2,
      OP_AND  = 4'h3,
      OP_OR   = 4'h4,
      OP_XOR  = 4'h5,
      OP_SHL  = 4'h6,
      OP_LDI  = 4'h7,
      OP_LD   = 4'h8,
      OP_ST   = 4'h9,
      OP_JMP  = 4'hA,
      OP_BZ   = 4'hB,
      OP_BC   = 4'hC,
      OP_CMP  = 4'hD,
      OP_HALT = 4'hE,
      OP_ILL  = 4'hF
   } opcode_e;

   localparam logic [1:0] ST_FETCH = 2'd0;
   localparam logic [1:0] ST_EXEC  = 2'd1;
   localparam logic [1:0] ST_MEM   = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   localparam int unsigned OP_LSB  = 12;
   localparam int unsigned RD_LSB  = 8;
   localparam int unsigned RS1_LSB = 4;
   localparam int unsigned RS2_LSB = 0;

   localparam int unsigned FLAG_Z = 0;
   localparam int unsigned FLAG_C = 1;

endpackage

// File: rtl/param_alu.sv
// Combinational ALU: result plus zero and carry/borrow for the arithmetic/logic opcodes.
module param_alu
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W = 8
) (
   input  opcode_e           op,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   output logic [DATA_W-1:0] result,
   output logic              zero,
   output logic              carry
);

   always_comb begin
      result = '0;
      carry  = 1'b0;
      case (op)
         OP_ADD:         {carry, result} = {1'b0, a} + {1'b0, b};
         OP_SUB, OP_CMP: begin
            result = a - b;
            carry  = (a < b);
         end
         OP_AND:         result = a & b;
         OP_OR:          result = a | b;
         OP_XOR:         result = a ^ b;
         OP_SHL:         {carry, result} = {a, 1'b0};
         default:        ;
      endcase
      zero = (result == '0);
   end

endmodule

// File: rtl/multicycle_cpu.sv
// Multi-cycle CPU core: FETCH/EXEC/MEM/HALT sequencer, inline register file, single req/ready memory port.
module multicycle_cpu
   import cpu_pkg::*;
#(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned RESET_PC = 0
) (
   input  logic              clk,
   input  logic              rst,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       mem_wdata,
   input  logic [15:0]       mem_rdata,
   input  logic              mem_ready,
   output logic              halted,
   output logic              illegal,
   output logic              retire
);

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [15:0]       inst_q, inst_d;
   logic [DATA_W-1:0] regs_q [16];
   logic [DATA_W-1:0] regs_d [16];
   logic [1:0]        flags_q, flags_d;
   logic              halted_q, halted_d;
   logic              illegal_q, illegal_d;
   logic              retire_q, retire_d;

   opcode_e           op;
   logic [3:0]        rd_idx, rs1_idx, rs2_idx;
   logic [DATA_W-1:0] rs1_val, rs2_val;
   logic [ADDR_W-1:0] rs1_addr;
   logic [DATA_W-1:0] alu_result;
   logic              alu_z, alu_c;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;

   assign op       = opcode_e'(inst_q[OP_LSB +: 4]);
   assign rd_idx   = inst_q[RD_LSB +: 4];
   assign rs1_idx  = inst_q[RS1_LSB +: 4];
   assign rs2_idx  = inst_q[RS2_LSB +: 4];
   assign rs1_val  = regs_q[rs1_idx];
   assign rs2_val  = regs_q[rs2_idx];
   assign rs1_addr = ADDR_W'(rs1_val);

   param_alu #(.DATA_W(DATA_W)) u_alu (
      .op     (op),
      .a      (rs1_val),
      .b      (rs2_val),
      .result (alu_result),
      .zero   (alu_z),
      .carry  (alu_c)
   );

   // Request is gated by rst so it is low during every reset cycle, including mid-transfer.
   assign mem_req   = !rst && ((state_q == ST_FETCH) || (state_q == ST_MEM));
   assign mem_we    = (state_q == ST_MEM) && (op == OP_ST);
   assign mem_addr  = (state_q == ST_MEM) ? rs1_addr : pc_q;
   assign mem_wdata = 16'(rs2_val);

   assign halted  = halted_q;
   assign illegal = illegal_q;
   assign retire  = retire_q;

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      inst_d    = inst_q;
      regs_d    = regs_q;
      flags_d   = flags_q;
      halted_d  = halted_q;
      illegal_d = illegal_q;
      retire_d  = 1'b0;
      wr_en     = 1'b0;
      wr_data   = alu_result;
      case (state_q)
         ST_FETCH: begin
            if (mem_ready) begin
               inst_d  = mem_rdata;
               pc_d    = pc_q + 1'b1;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            state_d  = ST_FETCH;
            retire_d = 1'b1;
            case (op)
               OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL: begin
                  wr_en           = 1'b1;
                  flags_d[FLAG_Z] = alu_z;
                  flags_d[FLAG_C] = alu_c;
               end
               OP_CMP: begin
                  flags_d[FLAG_Z] = alu_z;
                  flags_d[FLAG_C] = alu_c;
               end
               OP_LDI: begin
                  wr_en   = 1'b1;
                  wr_data = DATA_W'(inst_q[7:0]);
               end
               OP_LD, OP_ST: begin
                  state_d  = ST_MEM;
                  retire_d = 1'b0;
               end
               OP_JMP: pc_d = rs1_addr;
               OP_BZ:  if (flags_q[FLAG_Z]) pc_d = rs1_addr;
               OP_BC:  if (flags_q[FLAG_C]) pc_d = rs1_addr;
               OP_HALT: begin
                  state_d  = ST_HALT;
                  halted_d = 1'b1;
               end
               OP_ILL: begin
                  state_d   = ST_HALT;
                  halted_d  = 1'b1;
                  illegal_d = 1'b1;
                  retire_d  = 1'b0;
               end
               default: ;
            endcase
         end
         ST_MEM: begin
            if (mem_ready) begin
               wr_en    = (op == OP_LD);
               wr_data  = mem_rdata[DATA_W-1:0];
               retire_d = 1'b1;
               state_d  = ST_FETCH;
            end
         end
         default: ;
      endcase
      if (wr_en && (rd_idx != 4'd0)) regs_d[rd_idx] = wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_FETCH;
         pc_q      <= ADDR_W'(RESET_PC);
         inst_q    <= '0;
         flags_q   <= '0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
         retire_q  <= 1'b0;
         for (int unsigned i = 0; i < 16; i++) regs_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         inst_q    <= inst_d;
         flags_q   <= flags_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
         retire_q  <= retire_d;
         regs_q    <= regs_d;
      end
   end

endmodule

// File: tb/tb_multicycle_cpu.sv
// Scoreboard bench: an instruction-level model predicts every memory transaction, a monitor checks them.
module tb_multicycle_cpu;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 8;

   logic          clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst = 1'b1;
   logic          mem_req, mem_we, mem_ready;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_wdata, mem_rdata;
   logic          halted, illegal, retire;

   multicycle_cpu #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(0)) dut (
      .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
      .halted(halted), .illegal(illegal), .retire(retire)
   );

   logic          rst4 = 1'b1;
   logic          mem4_req, mem4_we, mem4_ready;
   logic [3:0]    mem4_addr;
   logic [15:0]   mem4_wdata, mem4_rdata;
   logic          halted4, illegal4, retire4;
   logic [15:0]   mem4 [16];

   assign mem4_ready = 1'b1;
   assign mem4_rdata = mem4[mem4_addr];

   multicycle_cpu #(.DATA_W(8), .ADDR_W(4), .RESET_PC(0)) dut4 (
      .clk(clk), .rst(rst4), .mem_req(mem4_req), .mem_we(mem4_we), .mem_addr(mem4_addr),
      .mem_wdata(mem4_wdata), .mem_rdata(mem4_rdata), .mem_ready(mem4_ready),
      .halted(halted4), .illegal(illegal4), .retire(retire4)
   );

   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [15:0]   wdata;
   } txn_t;

   txn_t          exp_q [$];
   logic [15:0]   mem     [256];
   logic [15:0]   ref_mem [256];
   int            checks = 0;
   int            errors = 0;
   int unsigned   min_wait = 0, max_wait = 0;
   bit            sb_en = 1'b0, expect_end = 1'b0, hold_en = 1'b0;
   logic [AW-1:0] hold_addr = '0;
   int unsigned   retire_cnt = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] enc(input int unsigned op, rd, rs1, rs2);
      return {4'(op), 4'(rd), 4'(rs1), 4'(rs2)};
   endfunction

   // Memory responder: random wait states, optional indefinite hold on one address.
   initial begin
      int unsigned wait_cnt;
      wait_cnt  = 0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!mem_req) begin
            mem_ready = 1'b0;
            mem_rdata = 16'($urandom);
            wait_cnt  = $urandom_range(max_wait, min_wait);
         end else if (wait_cnt == 0 && !(hold_en && mem_addr == hold_addr)) begin
            mem_ready = 1'b1;
            mem_rdata = mem[mem_addr];
            if (mem_we) mem[mem_addr] = mem_wdata;
            wait_cnt  = $urandom_range(max_wait, min_wait);
         end else begin
            mem_ready = 1'b0;
            mem_rdata = 16'($urandom);
            if (wait_cnt > 0) wait_cnt--;
         end
      end
   end

   // Monitor: checks request stability across waits and pops the scoreboard on each completion.
   initial begin
      bit   pend;
      txn_t held, t;
      pend = 1'b0;
      held = '0;
      forever begin
         @(negedge clk);
         #1;
         if (retire) retire_cnt++;
         if (pend && mem_req) begin
            check("req_stable_we", mem_we, held.we);
            check("req_stable_addr", mem_addr, held.addr);
            check("req_stable_wdata", mem_wdata, held.wdata);
         end
         if (mem_req && mem_ready && sb_en) begin
            if (exp_q.size() == 0) begin
               if (expect_end) begin
                  checks++;
                  errors++;
                  $display("FAIL extra_txn: got we=%0b addr=0x%0h expected no transfer", mem_we, mem_addr);
               end
            end else begin
               t = exp_q.pop_front();
               check("txn_we", mem_we, t.we);
               check("txn_addr", mem_addr, t.addr);
               if (t.we) check("txn_wdata", mem_wdata, t.wdata);
            end
         end
         pend = mem_req && !mem_ready;
         held = '{mem_we, mem_addr, mem_wdata};
      end
   end

   // Instruction-level reference model over a private copy of memory.
   task automatic run_iss(input int unsigned limit, output bit ended, output bit ill, output int unsigned nret);
      int unsigned r [16];
      int unsigned pc, op, rd, a, b, res;
      logic [15:0] inst;
      bit z, c, wr;
      foreach (r[i]) r[i] = 0;
      pc = 0; z = 0; c = 0;
      ended = 0; ill = 0; nret = 0;
      for (int unsigned step = 0; step < limit && !ended; step++) begin
         exp_q.push_back(txn_t'{1'b0, AW'(pc), 16'h0});
         inst = ref_mem[pc];
         pc   = (pc + 1) % 256;
         op   = inst[15:12];
         rd   = inst[11:8];
         a    = r[inst[7:4]];
         b    = r[inst[3:0]];
         res  = 0;
         wr   = 0;
         case (op)
            1:  begin res = (a + b) % 256; c = (a + b) > 255; z = (res == 0); wr = 1; end
            2:  begin res = (a + 256 - b) % 256; c = (a < b); z = (res == 0); wr = 1; end
            3:  begin res = a & b; c = 0; z = (res == 0); wr = 1; end
            4:  begin res = a | b; c = 0; z = (res == 0); wr = 1; end
            5:  begin res = a ^ b; c = 0; z = (res == 0); wr = 1; end
            6:  begin res = (a * 2) % 256; c = (a >= 128); z = (res == 0); wr = 1; end
            7:  begin res = inst[7:0]; wr = 1; end
            8:  begin exp_q.push_back(txn_t'{1'b0, AW'(a), 16'h0}); res = ref_mem[a] % 256; wr = 1; end
            9:  begin exp_q.push_back(txn_t'{1'b1, AW'(a), 16'(b)}); ref_mem[a] = 16'(b); end
            10: pc = a;
            11: if (z) pc = a;
            12: if (c) pc = a;
            13: begin c = (a < b); z = (a == b); end
            14: ended = 1;
            15: begin ended = 1; ill = 1; end
            default: ;
         endcase
         if (wr && rd != 0) r[rd] = res;
         if (op != 15) nret++;
      end
   endtask

   task automatic run_program(input string name, input int unsigned lim, minw, maxw, output int unsigned cyc);
      bit ended, ill;
      int unsigned nret, ret0;
      @(posedge clk);
      #2;
      rst = 1'b1;
      sb_en = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      exp_q.delete();
      foreach (mem[i]) ref_mem[i] = mem[i];
      run_iss(lim, ended, ill, nret);
      min_wait = minw;
      max_wait = maxw;
      expect_end = ended;
      check({name, "_rst_req"}, mem_req, 0);
      check({name, "_rst_halted"}, halted, 0);
      check({name, "_rst_illegal"}, illegal, 0);
      check({name, "_rst_retire"}, retire, 0);
      ret0 = retire_cnt;
      sb_en = 1'b1;
      rst = 1'b0;
      cyc = 0;
      while (cyc < 6000 && !(exp_q.size() == 0 && (!ended || halted))) begin
         @(negedge clk);
         #2;
         cyc++;
      end
      if (cyc >= 6000) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got %0d transfers outstanding expected 0", name, exp_q.size());
      end else if (ended) begin
         check({name, "_halted"}, halted, 1);
         check({name, "_illegal"}, illegal, 32'(ill));
         check({name, "_retires"}, retire_cnt - ret0, nret);
         repeat (3) @(negedge clk);
         #2;
         check({name, "_halt_no_req"}, mem_req, 0);
      end
      sb_en = 1'b0;
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned cyc, n, r4, op;
      logic [3:0]  got4 [$];

      // Basic program with zero-wait memory and instruction timing.
      foreach (mem[i]) mem[i] = 16'($urandom);
      mem[0] = 16'h7105; mem[1] = 16'h7203; mem[2] = 16'h1312; mem[3] = 16'hE000;
      run_program("basic", 100, 0, 0, cyc);
      check("basic_cycles_to_halt", cyc, 9);

      // 8-bit overflow: Z and C set, BZ and BC both taken.
      foreach (mem[i]) mem[i] = 16'($urandom);
      mem[0] = 16'h71FF; mem[1] = 16'h7201; mem[2] = 16'h1312; mem[3] = 16'h7420;
      mem[4] = 16'hB040; mem[5] = 16'hE000;
      mem[8'h20] = 16'h7430; mem[8'h21] = 16'hC040; mem[8'h22] = 16'hE000;
      mem[8'h30] = 16'h7660; mem[8'h31] = 16'h9063; mem[8'h32] = 16'hE000;
      mem[8'h60] = 16'h1234;
      run_program("ovf_branch", 100, 0, 1, cyc);
      check("ovf_sum_stored", mem[8'h60], 16'h0000);

      // Store then load through a slow memory.
      foreach (mem[i]) mem[i] = 16'($urandom);
      mem[0] = 16'h7140; mem[1] = 16'h72A5; mem[2] = 16'h9012; mem[3] = 16'h8510;
      mem[4] = 16'h7641; mem[5] = 16'h9065; mem[6] = 16'hE000;
      run_program("st_ld_wait3", 100, 3, 3, cyc);
      check("st_ld_value", mem[8'h41], 16'h00A5);

      // R0 stays zero.
      foreach (mem[i]) mem[i] = 16'($urandom);
      mem[0] = 16'h7007; mem[1] = 16'h1100; mem[2] = 16'h7250; mem[3] = 16'h9021;
      mem[4] = 16'h7351; mem[5] = 16'h9030; mem[6] = 16'hE000;
      mem[8'h50] = 16'hFFFF; mem[8'h51] = 16'hFFFF;
      run_program("r0_zero", 100, 0, 2, cyc);
      check("r0_add_result", mem[8'h50], 16'h0000);
      check("r0_store", mem[8'h51], 16'h0000);

      // Reset while a load waits: request abandoned, core restarts from RESET_PC.
      foreach (mem[i]) mem[i] = 16'($urandom);
      mem[0] = 16'h7533; mem[1] = 16'h7140; mem[2] = 16'h8510; mem[3] = 16'h7641;
      mem[4] = 16'h9065; mem[5] = 16'hE000; mem[8'h40] = 16'h00C3;
      @(posedge clk);
      #2;
      rst = 1'b1; hold_en = 1'b1; hold_addr = 8'h40; min_wait = 0; max_wait = 0;
      repeat (2) @(posedge clk);
      #2;
      rst = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         #2;
         n++;
      end while (!(mem_req && mem_addr == 8'h40) && n < 50);
      check("ld_req_seen", 32'(mem_req && mem_addr == 8'h40), 1);
      repeat (2) @(negedge clk);
      #2;
      check("ld_req_held", mem_req, 1);
      check("ld_req_read", mem_we, 0);
      @(posedge clk);
      #2;
      rst = 1'b1;
      @(negedge clk);
      #2;
      check("rst_drops_req", mem_req, 0);
      hold_en = 1'b0;
      run_program("after_rst", 100, 0, 1, cyc);
      check("after_rst_ld_value", mem[8'h41], 16'h00C3);

      // Random programs followed by a register dump.
      for (int t = 0; t < 16; t++) begin
         foreach (mem[i]) mem[i] = 16'($urandom);
         for (int i = 0; i < 24; i++) begin
            op = $urandom_range(13, 0);
            if ($urandom_range(31, 0) == 0) op = $urandom_range(15, 14);
            mem[i] = enc(op, $urandom_range(15, 0), $urandom_range(15, 0), $urandom_range(15, 0));
         end
         for (int i = 1; i < 16; i++) mem[23 + i] = enc(9, 0, 0, i);
         mem[39] = enc(14, 0, 0, 0);
         run_program("random", 200, 0, $urandom_range(3, 0), cyc);
      end

      // ADDR_W=4 core: PC wraps 15 -> 0, then an illegal opcode halts without retiring.
      foreach (mem4[i]) mem4[i] = 16'h0000;
      mem4[0] = 16'h710F;
      mem4[1] = 16'hA010;
      @(posedge clk);
      #2;
      check("aw4_rst_req", mem4_req, 0);
      rst4 = 1'b0;
      r4 = 0;
      n = 0;
      while (n < 40 && !halted4) begin
         @(negedge clk);
         #1;
         n++;
         if (mem4_req) got4.push_back(mem4_addr);
         if (mem4_req && mem4_addr == 4'd15) mem4[0] = 16'hF000;
         if (retire4) r4++;
      end
      check("aw4_fetch_count", got4.size(), 4);
      if (got4.size() == 4) begin
         check("aw4_fetch0", got4[0], 0);
         check("aw4_fetch1", got4[1], 1);
         check("aw4_fetch2", got4[2], 15);
         check("aw4_fetch_wrap", got4[3], 0);
      end
      check("aw4_halted", halted4, 1);
      check("aw4_illegal", illegal4, 1);
      check("aw4_retires", r4, 3);
      @(negedge clk);
      #1;
      check("aw4_halt_no_req", mem4_req, 0);
      check("aw4_no_retire_illegal", retire4, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
